// File: rtl/sim_report_collector_pkg.sv
// Shared types and defaults for the multi-channel end-of-simulation collector.
package sim_bench_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam int DEF_NCH         = 4;
   localparam int DEF_RW          = 32;
   localparam int DEF_DEPTH       = 8;
   localparam int DEF_TIMEOUT_CYC = 96000;
   localparam int DEF_CW          = 32;

   function automatic int chan_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sim_report_collector_if.sv
// Channel-side report/done bundle plus the serialised report output stream.
interface sim_report_if
   import sim_bench_pkg::*;
#(
   parameter int NCH = DEF_NCH,
   parameter int RW  = DEF_RW,
   parameter int CHW = chan_w(NCH)
);
   logic [NCH-1:0]    ch_done;
   logic [NCH-1:0]    ch_success;
   logic [NCH-1:0]    ch_report_valid;
   logic [NCH*RW-1:0] ch_report;
   logic [NCH-1:0]    ch_report_ready;
   logic              rpt_valid;
   logic [RW-1:0]     rpt_data;
   logic [CHW-1:0]    rpt_chan;
   logic              rpt_ready;

   modport master (
      output ch_done, ch_success, ch_report_valid, ch_report, rpt_ready,
      input  ch_report_ready, rpt_valid, rpt_data, rpt_chan
   );

   modport slave (
      input  ch_done, ch_success, ch_report_valid, ch_report, rpt_ready,
      output ch_report_ready, rpt_valid, rpt_data, rpt_chan
   );
endinterface

// File: rtl/sim_report_collector_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit for full/empty.
module sim_report_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
   assign count   = wr_ptr_q - rd_ptr_q;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/sim_report_collector.sv
// Collects per-channel done/success, serialises report words round-robin into a
// FIFO and runs the cycle watchdog that bounds the whole simulation.
module sim_report_collector
   import sim_bench_pkg::*;
#(
   parameter int NCH         = DEF_NCH,
   parameter int RW          = DEF_RW,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int CW          = DEF_CW
) (
   input  logic          refclk,
   input  logic          rst_n,
   sim_report_if.slave   bus,
   output logic          sim_done,
   output logic          sim_success,
   output logic          sim_timeout,
   output logic [CW-1:0] cycle_count
);
   localparam int CHW = chan_w(NCH);
   localparam int SW  = CHW + 1;
   localparam int FW  = RW + CHW;

   state_e               state_q, state_d;
   logic [NCH-1:0]       done_l_q, done_l_d;
   logic [NCH-1:0]       succ_l_q, succ_l_d;
   logic [NCH-1:0]       new_done;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [CHW-1:0]       ptr_q, ptr_d;
   logic                 timeout_q, timeout_d;
   logic                 sim_done_q, sim_done_d;
   logic                 sim_success_q, sim_success_d;

   logic [NCH-1:0]       grant;
   logic [CHW-1:0]       gnt_idx, cand;
   logic [SW-1:0]        sum;
   logic                 push;
   logic [FW-1:0]        fifo_rdata;
   logic                 fifo_full, fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;

   // Rotating priority: first valid channel at or after the pointer wins.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      cand    = '0;
      sum     = '0;
      push    = 1'b0;
      if (state_q == ST_RUN && !fifo_full) begin
         for (int k = 0; k < NCH; k++) begin
            sum = {1'b0, ptr_q} + SW'(k);
            if (sum >= SW'(NCH)) sum = sum - SW'(NCH);
            cand = sum[CHW-1:0];
            if (!push && bus.ch_report_valid[cand]) begin
               push    = 1'b1;
               gnt_idx = cand;
            end
         end
         if (push) grant[gnt_idx] = 1'b1;
      end
   end

   assign bus.ch_report_ready = grant;

   sim_report_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
      .clk   (refclk),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({gnt_idx, bus.ch_report[int'(gnt_idx)*RW +: RW]}),
      .pop   (bus.rpt_ready),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bus.rpt_valid = ~fifo_empty;
   assign bus.rpt_data  = fifo_empty ? '0 : fifo_rdata[RW-1:0];
   assign bus.rpt_chan  = fifo_empty ? '0 : fifo_rdata[RW +: CHW];

   always_comb begin
      state_d       = state_q;
      done_l_d      = done_l_q;
      succ_l_d      = succ_l_q;
      cnt_d         = cnt_q;
      ptr_d         = ptr_q;
      timeout_d     = timeout_q;
      sim_done_d    = sim_done_q;
      sim_success_d = sim_success_q;
      new_done      = '0;
      case (state_q)
         ST_RUN: begin
            new_done = bus.ch_done & ~done_l_q;
            done_l_d = done_l_q | bus.ch_done;
            succ_l_d = (succ_l_q & ~new_done) | (bus.ch_success & new_done);
            if (push) ptr_d = (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
            // All-done is tested first so it wins a tie with the watchdog.
            if (&done_l_d) begin
               state_d = ST_DRAIN;
            end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
               state_d   = ST_DRAIN;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (fifo_count == '0) state_d = ST_DONE;
         end
         ST_DONE: begin
            sim_done_d    = 1'b1;
            sim_success_d = (&succ_l_q) & ~timeout_q;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         done_l_q      <= '0;
         succ_l_q      <= '0;
         cnt_q         <= '0;
         ptr_q         <= '0;
         timeout_q     <= 1'b0;
         sim_done_q    <= 1'b0;
         sim_success_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         done_l_q      <= done_l_d;
         succ_l_q      <= succ_l_d;
         cnt_q         <= cnt_d;
         ptr_q         <= ptr_d;
         timeout_q     <= timeout_d;
         sim_done_q    <= sim_done_d;
         sim_success_q <= sim_success_d;
      end
   end

   assign sim_done    = sim_done_q;
   assign sim_success = sim_success_q;
   assign sim_timeout = timeout_q;
   assign cycle_count = cnt_q;
endmodule

// File: tb/tb_sim_report_collector.sv
// Randomised self-checking bench for sim_report_collector against a queue-based model.
module tb_sim_report_collector;
   import sim_bench_pkg::*;

   localparam int NCH = 4;
   localparam int RW  = 32;
   localparam int DEP = 4;
   localparam int TO  = 64;
   localparam int CW  = 32;

   logic          refclk = 1'b0;
   logic          rst_n;
   logic          sim_done, sim_success, sim_timeout;
   logic [CW-1:0] cycle_count;
   int            n_cmp = 0;
   int            n_bad = 0;

   int            dcyc [NCH];
   bit            dsucc [NCH];
   logic [RW-1:0] sw [NCH];
   int            mchan [$];
   logic [RW-1:0] mdata [$];
   int            mptr;

   sim_report_if #(.NCH(NCH), .RW(RW)) bus ();

   sim_report_collector #(
      .NCH(NCH), .RW(RW), .DEPTH(DEP), .TIMEOUT_CYC(TO), .CW(CW)
   ) dut (
      .refclk      (refclk),
      .rst_n       (rst_n),
      .bus         (bus),
      .sim_done    (sim_done),
      .sim_success (sim_success),
      .sim_timeout (sim_timeout),
      .cycle_count (cycle_count)
   );

   always #5 refclk = ~refclk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish, got running want finished");
      $fatal(1);
   end

   task automatic do_reset();
      bus.ch_done         = '0;
      bus.ch_success      = '0;
      bus.ch_report_valid = '0;
      bus.ch_report       = '0;
      bus.rpt_ready       = 1'b1;
      rst_n               = 1'b0;
      repeat (2) @(negedge refclk);
      rst_n = 1'b1;
      mptr  = 0;
      mchan.delete();
      mdata.delete();
   endtask

   // One report cycle: drive, check against the model, advance the model, step.
   task automatic rpt_step(input logic [NCH-1:0] v, input bit rdy, output int g,
                           output logic [NCH-1:0] seen);
      logic [NCH-1:0] exp_rdy;
      bus.ch_report_valid = v;
      for (int i = 0; i < NCH; i++) bus.ch_report[i*RW +: RW] = sw[i];
      bus.rpt_ready = rdy;
      #1;
      g = -1;
      if (mchan.size() < DEP)
         for (int k = 0; k < NCH; k++)
            if (g < 0 && v[(mptr + k) % NCH]) g = (mptr + k) % NCH;
      exp_rdy = (g >= 0) ? (NCH'(1) << g) : '0;
      seen = bus.ch_report_ready;
      n_cmp++;
      if (seen !== exp_rdy) begin
         n_bad++;
         $display("FAIL rr_grant got %b want %b", seen, exp_rdy);
      end
      n_cmp++;
      if (bus.rpt_valid !== (mchan.size() > 0)) begin
         n_bad++;
         $display("FAIL rpt_valid got %b want %0d", bus.rpt_valid, mchan.size() > 0);
      end
      if (mchan.size() > 0) begin
         n_cmp++;
         if (bus.rpt_chan !== 2'(mchan[0]) || bus.rpt_data !== mdata[0]) begin
            n_bad++;
            $display("FAIL rpt_head got ch%0d %h want ch%0d %h",
                     bus.rpt_chan, bus.rpt_data, mchan[0], mdata[0]);
         end
         if (rdy) begin
            void'(mchan.pop_front());
            void'(mdata.pop_front());
         end
      end
      if (g >= 0) begin
         mchan.push_back(g);
         mdata.push_back(sw[g]);
         mptr = (g + 1) % NCH;
      end
      @(negedge refclk);
   endtask

   task automatic test_reset();
      do_reset();
      rst_n = 1'b0;
      #2;
      n_cmp++;
      if ({sim_done, sim_success, sim_timeout, bus.rpt_valid} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_flags got %b want 0000",
                  {sim_done, sim_success, sim_timeout, bus.rpt_valid});
      end
      n_cmp++;
      if (cycle_count !== '0 || bus.ch_report_ready !== '0) begin
         n_bad++;
         $display("FAIL reset_count got %0d/%b want 0/0000", cycle_count, bus.ch_report_ready);
      end
      @(negedge refclk);
      rst_n = 1'b1;
   endtask

   // Done/success/timeout outcome derived from the per-channel done cycles.
   task automatic run_done(input string nm);
      int last, drain_c, exp_cnt;
      bit all_d, exp_to, exp_succ;
      all_d = 1'b1;
      last  = -1;
      exp_succ = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         if (dcyc[i] < 0) all_d = 1'b0;
         else if (dcyc[i] > last) last = dcyc[i];
         exp_succ &= dsucc[i];
      end
      if (all_d && last <= TO - 1) begin
         drain_c = last + 1;
         exp_cnt = last;
         exp_to  = 1'b0;
      end else begin
         drain_c  = TO;
         exp_cnt  = TO - 1;
         exp_to   = 1'b1;
         exp_succ = 1'b0;
      end
      do_reset();
      for (int c = 0; c <= drain_c + 2; c++) begin
         for (int i = 0; i < NCH; i++) begin
            bus.ch_done[i]    = (dcyc[i] >= 0 && c >= dcyc[i]);
            bus.ch_success[i] = (c == dcyc[i]) ? dsucc[i] : 1'($urandom);
         end
         if (c == drain_c / 2) begin
            n_cmp++;
            if (cycle_count !== CW'(c)) begin
               n_bad++;
               $display("FAIL %s count_mid got %0d want %0d", nm, cycle_count, c);
            end
         end
         if (c == drain_c + 1) begin
            n_cmp++;
            if (sim_done !== 1'b0) begin
               n_bad++;
               $display("FAIL %s done_early got %b want 0", nm, sim_done);
            end
         end
         if (c == drain_c + 2) begin
            n_cmp++;
            if ({sim_done, sim_success, sim_timeout} !== {1'b1, exp_succ, exp_to}) begin
               n_bad++;
               $display("FAIL %s done/succ/to got %b%b%b want 1%b%b",
                        nm, sim_done, sim_success, sim_timeout, exp_succ, exp_to);
            end
            n_cmp++;
            if (cycle_count !== CW'(exp_cnt)) begin
               n_bad++;
               $display("FAIL %s count_final got %0d want %0d", nm, cycle_count, exp_cnt);
            end
         end
         @(negedge refclk);
      end
   endtask

   task automatic test_done_cases();
      dcyc = '{5, 9, 12, 20};   dsucc = '{1, 1, 1, 1}; run_done("all_pass");
      dcyc = '{3, 7, 4, 11};    dsucc = '{1, 1, 0, 1}; run_done("ch2_fail");
      dcyc = '{2, 6, 10, -1};   dsucc = '{1, 1, 1, 1}; run_done("timeout");
      dcyc = '{10, 20, 30, 63}; dsucc = '{1, 1, 1, 1}; run_done("tie_63");
      dcyc = '{0, 0, 0, 0};     dsucc = '{1, 1, 1, 1}; run_done("all_at_0");
      for (int r = 0; r < 5; r++) begin
         for (int i = 0; i < NCH; i++) begin
            dcyc[i]  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 75));
            dsucc[i] = ($urandom_range(0, 3) != 0);
         end
         run_done("random_done");
      end
   endtask

   task automatic test_rotation();
      int g;
      int gseq [$];
      logic [NCH-1:0] seen;
      int want [5] = '{0, 1, 2, 3, 0};
      do_reset();
      for (int i = 0; i < NCH; i++) sw[i] = 32'hA0 + 32'(i);
      for (int s = 0; s < 8; s++) begin
         rpt_step('1, 1'b1, g, seen);
         for (int i = 0; i < NCH; i++) if (seen[i]) gseq.push_back(i);
      end
      for (int s = 0; s < 5; s++) begin
         n_cmp++;
         if (s >= gseq.size() || gseq[s] != want[s]) begin
            n_bad++;
            $display("FAIL rotation_seq[%0d] got %0d want %0d", s,
                     (s < gseq.size()) ? gseq[s] : -1, want[s]);
         end
      end
      for (int s = 0; s < 6; s++) rpt_step('0, 1'b1, g, seen);
      n_cmp++;
      if (bus.rpt_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rotation_drained got %b want 0", bus.rpt_valid);
      end
   endtask

   task automatic test_backpressure();
      int g, acc;
      logic [NCH-1:0] seen;
      do_reset();
      acc = 0;
      for (int s = 0; s < 5; s++) begin
         sw[0] = 32'hB000_0000 + 32'(s);
         rpt_step(4'b0001, 1'b0, g, seen);
         acc += int'(seen[0]);
      end
      n_cmp++;
      if (acc != DEP) begin
         n_bad++;
         $display("FAIL backpressure_accepts got %0d want %0d", acc, DEP);
      end
      for (int s = 0; s < 8; s++) begin
         sw[0] = 32'hC000_0000 + 32'(s);
         rpt_step(4'b0001, 1'b1, g, seen);
      end
      for (int s = 0; s < 6; s++) rpt_step('0, 1'b1, g, seen);
   endtask

   task automatic test_random_reports();
      int g;
      logic [NCH-1:0] seen;
      do_reset();
      for (int s = 0; s < 40; s++) begin
         for (int i = 0; i < NCH; i++) sw[i] = $urandom;
         rpt_step(NCH'($urandom), ($urandom_range(0, 2) != 0), g, seen);
      end
      for (int s = 0; s < 6; s++) rpt_step('0, 1'b1, g, seen);
   endtask

   task automatic test_drain_pending();
      do_reset();
      for (int i = 0; i < NCH; i++) bus.ch_report[i*RW +: RW] = 32'hA0 + 32'(i);
      bus.ch_done = '1;
      bus.ch_success = '1;
      bus.ch_report_valid = '1;
      bus.rpt_ready = 1'b0;
      for (int c = 0; c <= 9; c++) begin
         if (c == 6) bus.rpt_ready = 1'b1;
         #1;
         if (c == 0) begin
            n_cmp++;
            if (bus.ch_report_ready !== 4'b0001) begin
               n_bad++;
               $display("FAIL drain_first_grant got %b want 0001", bus.ch_report_ready);
            end
         end
         if (c == 1) begin
            n_cmp++;
            if (bus.ch_report_ready !== 4'b0000 || bus.rpt_valid !== 1'b1 ||
                bus.rpt_data !== 32'hA0) begin
               n_bad++;
               $display("FAIL drain_no_grant got %b/%b/%h want 0000/1/a0",
                        bus.ch_report_ready, bus.rpt_valid, bus.rpt_data);
            end
         end
         if (c == 8 || c == 5) begin
            n_cmp++;
            if (sim_done !== 1'b0) begin
               n_bad++;
               $display("FAIL drain_wait c%0d got %b want 0", c, sim_done);
            end
         end
         if (c == 9) begin
            n_cmp++;
            if ({sim_done, sim_success, sim_timeout} !== 3'b110 || cycle_count !== '0) begin
               n_bad++;
               $display("FAIL drain_done got %b%b%b cnt %0d want 110 cnt 0",
                        sim_done, sim_success, sim_timeout, cycle_count);
            end
         end
         @(negedge refclk);
      end
   endtask

   task automatic test_midrun_reset();
      int g;
      logic [NCH-1:0] seen;
      do_reset();
      for (int s = 0; s < 3; s++) begin
         sw[0] = 32'hD0 + 32'(s);
         rpt_step(4'b0001, 1'b0, g, seen);
      end
      @(posedge refclk);
      #3;
      bus.ch_report_valid = '0;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({sim_done, sim_success, sim_timeout, bus.rpt_valid} !== 4'b0000 ||
          cycle_count !== '0) begin
         n_bad++;
         $display("FAIL midrun_reset got %b cnt %0d want 0000 cnt 0",
                  {sim_done, sim_success, sim_timeout, bus.rpt_valid}, cycle_count);
      end
      @(negedge refclk);
      rst_n = 1'b1;
      @(negedge refclk);
      #1;
      n_cmp++;
      if (bus.rpt_valid !== 1'b0 || cycle_count !== CW'(1)) begin
         n_bad++;
         $display("FAIL midrun_after got %b cnt %0d want 0 cnt 1", bus.rpt_valid, cycle_count);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_done_cases();
      test_rotation();
      test_backpressure();
      test_random_reports();
      test_drain_pending();
      test_midrun_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
